// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer sitting between the program
// counter register, the instruction memory and the decode stage.
// One request outstanding at most, a one-cycle bubble between fetches, and
// redirects (branch/jump targets from execute) that can arrive at any time.
//
// Optional feature: define FETCH_CTRL_PERF_EN to build the fetch/stall
// performance counters; otherwise both counter ports read as zero.
module fetch_controller #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_en,
  output logic [WIDTH-1:0] next_pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [31:0]      if_instr,
  input  logic             if_ready,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_stall_cnt
);

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_if_valid;
  logic [WIDTH-1:0] r_if_pc;
  logic [31:0]      r_if_instr;
  logic             r_pending;
  logic [WIDTH-1:0] r_pending_pc;

  logic             w_if_valid_next;
  logic [WIDTH-1:0] w_if_pc_next;
  logic [31:0]      w_if_instr_next;
  logic             w_pending_next;
  logic [WIDTH-1:0] w_pending_pc_next;
  logic             w_pc_en;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_imem_req;
  logic [WIDTH-1:0] w_imem_addr;
  logic [WIDTH-1:0] w_redirect_target;

  // Redirect targets are forced to word alignment.
  assign w_redirect_target = {redirect_pc[WIDTH-1:2], 2'b00};

  // Next-state and output decode; reset overrides everything so no output
  // (including the combinational PC load strobe) leaks while rst is low.
  always_comb begin
    w_state_next      = r_state;
    w_pc_en           = 1'b0;
    w_next_pc         = '0;
    w_imem_req        = 1'b0;
    w_imem_addr       = '0;
    w_if_valid_next   = r_if_valid;
    w_if_pc_next      = r_if_pc;
    w_if_instr_next   = r_if_instr;
    w_pending_next    = r_pending;
    w_pending_pc_next = r_pending_pc;

    case (r_state)
      START: begin
        w_pc_en         = 1'b1;
        w_next_pc       = redirect_valid ? w_redirect_target : RESET_PC;
        w_if_valid_next = 1'b0;
        w_state_next    = FETCH;
      end

      FETCH: begin
        w_imem_req  = 1'b1;
        w_imem_addr = pc;
        if (imem_ack) begin
          w_pc_en        = 1'b1;
          w_pending_next = 1'b0;
          if (redirect_valid) begin
            w_next_pc = w_redirect_target;
          end else if (r_pending) begin
            w_next_pc = r_pending_pc;
          end else begin
            w_next_pc       = pc + WIDTH'(4);
            w_if_valid_next = 1'b1;
            w_if_pc_next    = pc;
            w_if_instr_next = imem_rdata;
            w_state_next    = HOLD;
          end
        end else if (redirect_valid) begin
          w_pending_next    = 1'b1;
          w_pending_pc_next = w_redirect_target;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          w_pc_en         = 1'b1;
          w_next_pc       = w_redirect_target;
          w_if_valid_next = 1'b0;
          w_state_next    = FETCH;
        end else if (if_ready && !stall) begin
          w_if_valid_next = 1'b0;
          w_state_next    = FETCH;
        end
      end

      default: begin
        w_state_next = START;
      end
    endcase

    if (!rst) begin
      w_state_next      = START;
      w_pc_en           = 1'b0;
      w_next_pc         = '0;
      w_imem_req        = 1'b0;
      w_imem_addr       = '0;
      w_if_valid_next   = 1'b0;
      w_if_pc_next      = '0;
      w_if_instr_next   = '0;
      w_pending_next    = 1'b0;
      w_pending_pc_next = '0;
    end
  end

  // State, delivered-instruction and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= START;
      r_if_valid   <= 1'b0;
      r_if_pc      <= '0;
      r_if_instr   <= '0;
      r_pending    <= 1'b0;
      r_pending_pc <= '0;
    end else begin
      r_state      <= w_state_next;
      r_if_valid   <= w_if_valid_next;
      r_if_pc      <= w_if_pc_next;
      r_if_instr   <= w_if_instr_next;
      r_pending    <= w_pending_next;
      r_pending_pc <= w_pending_pc_next;
    end
  end

  assign pc_en     = w_pc_en;
  assign next_pc   = w_next_pc;
  assign imem_req  = w_imem_req;
  assign imem_addr = w_imem_addr;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_stall_cnt;

  // Count delivered instructions and cycles where decode holds a valid one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetch_cnt <= '0;
      r_perf_stall_cnt <= '0;
    end else begin
      if (r_if_valid && if_ready && !stall) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (r_if_valid && stall) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_stall_cnt = r_perf_stall_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed, table-driven bench for fetch_controller.
// Includes a small PC register that loads next_pc on pc_en, as the
// surrounding pipeline would.
module tb_fetch_controller;

`ifdef FETCH_CTRL_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        pcEn;
    logic [31:0] nextPc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ifPc;
    logic [31:0] ifInstr;
  } vec_t;

  vec_t vecs[$];

  fetch_controller #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_en          (pc_en),
    .next_pc        (next_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Program counter register owned by the pipeline, loaded on pc_en.
  always_ff @(posedge clk) begin
    if (!rst) pc <= 32'h0;
    else if (pc_en) pc <= next_pc;
  end

  // Hard stop in case the sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input logic r, input logic rv, input logic [31:0] rpc,
                        input logic st, input logic ack, input logic [31:0] rd,
                        input logic rdy, input logic pe, input logic [31:0] np,
                        input logic rq, input logic [31:0] ad, input logic vl,
                        input logic [31:0] ip, input logic [31:0] ii);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.stall = st; v.ack = ack;
    v.rdata = rd; v.ready = rdy; v.pcEn = pe; v.nextPc = np; v.req = rq;
    v.addr = ad; v.valid = vl; v.ifPc = ip; v.ifInstr = ii;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic st, input logic ack, input logic [31:0] rd,
                               input logic rdy);
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    imem_ack       = ack;
    imem_rdata     = rd;
    if_ready       = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // next_pc is only meaningful with pc_en, the address only with a request and
  // the delivered fields only with if_valid; all are forced to zero in reset.
  task automatic checkAll(input string tag, input logic inRst, input logic pe,
                          input logic [31:0] np, input logic rq, input logic [31:0] ad,
                          input logic vl, input logic [31:0] ip, input logic [31:0] ii);
    checkOutput({tag, ".pc_en"}, {31'b0, pc_en}, {31'b0, pe});
    if (pe || inRst) checkOutput({tag, ".next_pc"}, next_pc, np);
    checkOutput({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, rq});
    if (rq || inRst) checkOutput({tag, ".imem_addr"}, imem_addr, ad);
    checkOutput({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, vl});
    if (vl || inRst) begin
      checkOutput({tag, ".if_pc"}, if_pc, ip);
      checkOutput({tag, ".if_instr"}, if_instr, ii);
    end
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;

    //     rst rv rpc           st ack rdata         rdy | pe np           rq addr         vl ifPc         ifInstr
    addVec(0, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 1, 32'h11111111, 0,   1, 32'h4,        1, 32'h0,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h11111111);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 1, 32'h22222222, 0,   1, 32'h8,        1, 32'h4,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h22222222);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 1, 32'h33333333, 0,   1, 32'hC,        1, 32'h8,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h33333333);
    addVec(1, 1, 32'h8,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'hC,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 1, 32'h44444444, 0,   1, 32'h8,        1, 32'hC,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0);
    addVec(1, 1, 32'h103,      0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h8,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0,   1, 32'h100,      1, 32'h8,        0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h100,      0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 1, 32'h55555555, 0,   1, 32'h104,      1, 32'h100,      0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        1, 32'h100,      32'h55555555);
    addVec(1, 1, 32'h206,      0, 0, 32'h0,        0,   1, 32'h204,      0, 32'h0,        1, 32'h100,      32'h55555555);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h204,      0, 32'h0,        32'h0);
    addVec(1, 1, 32'h40,       0, 1, 32'h99999999, 0,   1, 32'h40,       1, 32'h204,      0, 32'h0,        32'h0);
    addVec(1, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        1, 32'h40,       0, 32'h0,        32'h0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].stall,
                    vecs[i].ack, vecs[i].rdata, vecs[i].ready);
      checkAll($sformatf("v%0d", i), !vecs[i].rst, vecs[i].pcEn, vecs[i].nextPc,
               vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].ifPc, vecs[i].ifInstr);
    end

    // Stall: ack under stall still completes, then four held cycles.
    applyStimulus(1, 0, 32'h0, 1, 1, 32'h66666666, 1);
    checkAll("stallAck", 0, 1, 32'h44, 1, 32'h40, 0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 32'h0, 1, 0, 32'h0, 1);
      checkAll($sformatf("stallHold%0d", k), 0, 0, 32'h0, 0, 32'h0, 1, 32'h40, 32'h66666666);
    end
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 1);
    checkAll("stallRelease", 0, 0, 32'h0, 0, 32'h0, 1, 32'h40, 32'h66666666);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0);
    checkAll("afterStall", 0, 0, 32'h0, 1, 32'h44, 0, 32'h0, 32'h0);
    checkOutput("perfStallCnt", perf_stall_cnt, PerfOn ? 32'd4 : 32'd0);
    checkOutput("perfFetchCnt", perf_fetch_cnt, PerfOn ? 32'd4 : 32'd0);

    // Address wrap: redirect to the top word, then its successor is zero.
    applyStimulus(1, 1, 32'hFFFFFFFF, 0, 1, 32'h12345678, 0);
    checkAll("wrapRedirect", 0, 1, 32'hFFFFFFFC, 1, 32'h44, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0);
    checkAll("wrapReq", 0, 0, 32'h0, 1, 32'hFFFFFFFC, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 1, 32'h77777777, 0);
    checkAll("wrapAck", 0, 1, 32'h0, 1, 32'hFFFFFFFC, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0);
    checkAll("wrapDeliver", 0, 0, 32'h0, 0, 32'h0, 1, 32'hFFFFFFFC, 32'h77777777);

    // Two redirects while pending: the newer target wins.
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 1);
    checkAll("dblAccept", 0, 0, 32'h0, 0, 32'h0, 1, 32'hFFFFFFFC, 32'h77777777);
    applyStimulus(1, 1, 32'h200, 0, 0, 32'h0, 0);
    checkAll("dblRedir1", 0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0);
    applyStimulus(1, 1, 32'h300, 0, 0, 32'h0, 0);
    checkAll("dblRedir2", 0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 1, 32'hBADBAD00, 0);
    checkAll("dblAck", 0, 1, 32'h300, 1, 32'h0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0);
    checkAll("dblFetch", 0, 0, 32'h0, 1, 32'h300, 0, 32'h0, 32'h0);

    // Reset mid-request, then late acks during and just after reset.
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 0);
    checkOutput("rstReqDrop", {31'b0, imem_req}, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'hAAAAAAAA, 0);
    checkAll("rstHeld", 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0);
    checkOutput("rstPerfFetch", perf_fetch_cnt, 32'h0);
    checkOutput("rstPerfStall", perf_stall_cnt, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 1, 32'hAAAAAAAA, 0);
    checkAll("rstStart", 0, 1, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0);
    checkAll("rstFetch", 0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0);
    checkAll("rstNoLate", 0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
